// File: rtl/maxp_out_reorder_pkg.sv
// Shared types and helpers for the max-pool output reorder stage.
package maxp_out_reorder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Side-band carried with every read beat down to the output register.
  typedef struct packed {
    logic last;
    logic bank;
  } beat_tag_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reorder_dp_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port with enable.
module reorder_dp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/maxp_out_reorder.sv
// Reorders a pixel-major, channel-interleaved pooled stream into channel-planar
// frames through two ping-pong banks and a valid/ready output skid buffer.
module maxp_out_reorder
  import maxp_out_reorder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IMAGE_WIDTH  = 8,
  parameter int unsigned IMAGE_HEIGHT = 8,
  parameter int unsigned CHANNEL_NUM  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done,
  output logic                  overflow
);

  localparam int unsigned PIX        = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int unsigned FRAME      = PIX * CHANNEL_NUM;
  localparam int unsigned ADDR_WIDTH = clog2_min1(FRAME);
  localparam int unsigned PIX_WIDTH  = clog2_min1(PIX);
  localparam int unsigned CH_WIDTH   = clog2_min1(CHANNEL_NUM);
  localparam int unsigned RAM_AW     = ADDR_WIDTH + 1;

  logic                  wr_bank;
  logic [ADDR_WIDTH-1:0] wr_cnt;
  logic [1:0]            bank_full;
  logic                  pop_c;
  logic                  last_accept_c;
  logic [1:0]            free_mask_c;
  logic [1:0]            set_mask_c;
  logic                  wr_en_c;
  logic                  wr_wrap_c;
  logic                  drop_c;

  rd_state_e             state;
  rd_state_e             state_nxt;
  logic                  rd_bank;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PIX_WIDTH-1:0]  p_cnt;
  logic [CH_WIDTH-1:0]   c_cnt;
  logic                  p_last_c;
  logic                  c_last_c;
  logic [1:0]            occ_c;
  logic                  space_c;
  logic                  issue_c;
  logic                  final_issue_c;

  logic                  rd_vld;
  beat_tag_t             rd_tag;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  head_bank;
  logic                  tail_vld;
  beat_tag_t             tail_tag;
  logic [DATA_WIDTH-1:0] tail_data;

  // A bank is released when the beat that closes its frame leaves the output register.
  assign pop_c         = valid_out & out_ready;
  assign last_accept_c = pop_c & frame_done;
  assign free_mask_c   = {last_accept_c & head_bank, last_accept_c & ~head_bank};

  // The same-cycle free wins, so a write into a bank being released is kept.
  assign wr_en_c   = valid_in & ~(bank_full[wr_bank] & ~free_mask_c[wr_bank]);
  assign drop_c    = valid_in & ~wr_en_c;
  assign wr_wrap_c = wr_en_c & (wr_cnt == ADDR_WIDTH'(FRAME - 1));
  assign set_mask_c = {wr_wrap_c & wr_bank, wr_wrap_c & ~wr_bank};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_bank   <= 1'b0;
      wr_cnt    <= '0;
      bank_full <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wr_cnt <= wr_wrap_c ? '0 : wr_cnt + ADDR_WIDTH'(1);
        if (wr_wrap_c) wr_bank <= ~wr_bank;
      end
      bank_full <= (bank_full & ~free_mask_c) | set_mask_c;
      overflow  <= overflow | drop_c;
    end
  end

  // Beats committed downstream of the address stage never exceed the two skid slots.
  assign occ_c    = 2'(valid_out) + 2'(tail_vld) + 2'(rd_vld);
  assign space_c  = (occ_c - 2'(pop_c)) < 2'd2;
  assign p_last_c = (p_cnt == PIX_WIDTH'(PIX - 1));
  assign c_last_c = (c_cnt == CH_WIDTH'(CHANNEL_NUM - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Staying in READ when the other bank is already full lets frames stream gap-free.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bank_full[rd_bank]) state_nxt = READ;
      READ:    if (final_issue_c && !bank_full[~rd_bank]) state_nxt = DRAIN;
      DRAIN:   if (last_accept_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    issue_c       = 1'b0;
    final_issue_c = 1'b0;
    if (state == READ) begin
      issue_c       = space_c;
      final_issue_c = space_c & p_last_c & c_last_c;
    end
  end

  // Planar address walk: stride CHANNEL_NUM across pixels, restart at next channel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_bank <= 1'b0;
      rd_addr <= '0;
      p_cnt   <= '0;
      c_cnt   <= '0;
      rd_vld  <= 1'b0;
      rd_tag  <= '0;
    end else begin
      rd_vld <= issue_c;
      if (issue_c) begin
        rd_tag.last <= final_issue_c;
        rd_tag.bank <= rd_bank;
        if (p_last_c) begin
          p_cnt <= '0;
          if (c_last_c) begin
            c_cnt   <= '0;
            rd_addr <= '0;
            rd_bank <= ~rd_bank;
          end else begin
            c_cnt   <= c_cnt + CH_WIDTH'(1);
            rd_addr <= ADDR_WIDTH'(c_cnt) + ADDR_WIDTH'(1);
          end
        end else begin
          p_cnt   <= p_cnt + PIX_WIDTH'(1);
          rd_addr <= rd_addr + ADDR_WIDTH'(CHANNEL_NUM);
        end
      end
    end
  end

  reorder_dp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en_c),
    .waddr ({wr_bank, wr_cnt}),
    .wdata (pxl_in),
    .re    (issue_c),
    .raddr ({rd_bank, rd_addr}),
    .rdata (ram_q)
  );

  // Two-entry skid: the head register drives the outputs, the tail absorbs a stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_out  <= 1'b0;
      pxl_out    <= '0;
      frame_done <= 1'b0;
      head_bank  <= 1'b0;
      tail_vld   <= 1'b0;
      tail_data  <= '0;
      tail_tag   <= '0;
    end else if (!valid_out || pop_c) begin
      if (tail_vld) begin
        valid_out  <= 1'b1;
        pxl_out    <= tail_data;
        frame_done <= tail_tag.last;
        head_bank  <= tail_tag.bank;
        tail_vld   <= rd_vld;
        if (rd_vld) begin
          tail_data <= ram_q;
          tail_tag  <= rd_tag;
        end
      end else begin
        valid_out  <= rd_vld;
        frame_done <= rd_vld & rd_tag.last;
        if (rd_vld) begin
          pxl_out   <= ram_q;
          head_bank <= rd_tag.bank;
        end
      end
    end else if (rd_vld) begin
      tail_vld  <= 1'b1;
      tail_data <= ram_q;
      tail_tag  <= rd_tag;
    end
  end

endmodule

// File: tb/tb_maxp_out_reorder.sv
// Scoreboard bench for maxp_out_reorder: directed ramps checked against planar order.
module tb_maxp_out_reorder;

  localparam int unsigned DW  = 32;
  localparam int unsigned CH  = 4;
  localparam int unsigned PIX = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_in;
  logic [DW-1:0] pxl_in;
  logic          out_ready;
  logic [DW-1:0] pxl_out;
  logic          valid_out;
  logic          frame_done;
  logic          overflow;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            first_valid_cyc = 0;
  int            first_acc_cyc = 0;
  int            last_acc_cyc = 0;
  int            t_last = 0;
  bit            seen_valid = 1'b0;
  bit            seen_acc = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_pxl = '0;

  maxp_out_reorder #(
    .DATA_WIDTH   (DW),
    .IMAGE_WIDTH  (8),
    .IMAGE_HEIGHT (8),
    .CHANNEL_NUM  (CH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .out_ready  (out_ready),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat and watches stall stability.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", DW'(valid_out), 1);
        check("hold_pxl", pxl_out, prev_pxl);
      end
      if (valid_out && !seen_valid) begin
        seen_valid      = 1'b1;
        first_valid_cyc = cyc;
      end
      if (frame_done && !valid_out) check("done_without_valid", DW'(frame_done), 0);
      if (valid_out && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got %0d expected no beat (cycle %0d)", pxl_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          check("pxl_out", pxl_out, mon_e.data);
          check("frame_done", DW'(frame_done), DW'(mon_e.last));
        end
        if (!seen_acc) begin
          seen_acc      = 1'b1;
          first_acc_cyc = cyc;
        end
        last_acc_cyc = cyc;
      end
      prev_stall = valid_out && !out_ready;
      prev_pxl   = pxl_out;
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d);
    @(posedge clk);
    #1;
    valid_in = v;
    pxl_in   = d;
  endtask

  // Returns the cycle number of the edge that samples the final beat.
  task automatic feed(input int base, input int n, input bit gaps, output int last_edge);
    last_edge = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 0) drive(1'b0, '0);
      end
      drive(1'b1, DW'(base + i));
      last_edge = cyc + 1;
    end
    drive(1'b0, '0);
  endtask

  task automatic expect_frame(input int base);
    exp_t e;
    for (int c = 0; c < CH; c++) begin
      for (int p = 0; p < PIX; p++) begin
        e.data = DW'(base + p * CH + c);
        e.last = (c == CH - 1) && (p == PIX - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d beats outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_idle_valid"}, DW'(valid_out), 0);
  endtask

  task automatic check_cleared(input string name);
    @(negedge clk);
    check({name, "_pxl_out"}, pxl_out, 0);
    check({name, "_valid_out"}, DW'(valid_out), 0);
    check({name, "_frame_done"}, DW'(frame_done), 0);
    check({name, "_overflow"}, DW'(overflow), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    valid_in  = 1'b0;
    pxl_in    = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    check_cleared("reset");
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single contiguous ramp, steady out_ready.
    seen_valid = 1'b0;
    expect_frame(0);
    feed(0, 256, 1'b0, t_last);
    drain("ramp");
    check("latency", DW'(first_valid_cyc - t_last), 3);

    // Two contiguous frames must leave the output back to back.
    seen_acc = 1'b0;
    expect_frame(0);
    expect_frame(256);
    feed(0, 512, 1'b0, t_last);
    drain("two_frames");
    check("no_gap", DW'(last_acc_cyc - first_acc_cyc), 511);
    check("two_frames_overflow", DW'(overflow), 0);

    // Input with random gaps.
    expect_frame(0);
    feed(0, 256, 1'b1, t_last);
    drain("gaps");

    // Stalled output while three frames arrive: the third is dropped.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    expect_frame(0);
    expect_frame(256);
    feed(0, 768, 1'b0, t_last);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("stall_overflow", DW'(overflow), 1);
    check("stall_valid", DW'(valid_out), 1);
    check("stall_head", pxl_out, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain("stall3");
    check("stall_overflow_sticky", DW'(overflow), 1);

    // out_ready toggling every cycle.
    expect_frame(0);
    fork
      feed(0, 256, 1'b0, t_last);
      begin
        repeat (800) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain("toggle");

    // Reset in the middle of a frame, then a fresh frame.
    feed(1000, 100, 1'b0, t_last);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    expect_frame(0);
    feed(0, 256, 1'b0, t_last);
    drain("post_reset");
    check("post_reset_overflow", DW'(overflow), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
